// File: rtl/video_timing_detector_pkg.sv
// Shared types and nominal raster geometry for the video timing detector.
package video_timing_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } vtd_state_e;

    localparam int NOM_HOR_ACTIVE  = 640;
    localparam int NOM_VER_ACTIVE  = 480;
    localparam int NOM_HOR_TOTAL   = 800;
    localparam int NOM_VER_TOTAL   = 525;
    localparam int NOM_LOCK_FRAMES = 2;

endpackage

// File: rtl/video_timing_detector_if.sv
// Raster timing input bundle: hs/vs/de sampled on every clk_rgb edge where ce=1.
interface video_timing_detector_if;
    // ce qualifies each sample; there is no backpressure, the source never stalls for the sink.
    logic ce;
    logic hs_in;
    logic vs_in;
    logic de_in;

    modport master (output ce, hs_in, vs_in, de_in);
    modport slave  (input  ce, hs_in, vs_in, de_in);
endinterface

// File: rtl/video_timing_detector_sync_edge_detector.sv
// Pixel-enable gated previous-value register with same-cycle rise/fall qualifiers.
module sync_edge_detector (
    input  logic clk_rgb,
    input  logic rst,
    input  logic ce,
    input  logic sig_in,
    output logic rise,
    output logic fall
);
    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = prev_q;
        if (ce) prev_d = sig_in;
    end

    always_ff @(posedge clk_rgb) begin
        if (rst) prev_q <= 1'b0;
        else     prev_q <= prev_d;
    end

    assign rise = ce & sig_in & ~prev_q;
    assign fall = ce & ~sig_in & prev_q;
endmodule

// File: rtl/video_timing_detector.sv
// Recovers pixel coordinates and start strobes from hs/vs/de, measures active size and tracks lock.
module video_timing_detector
    import video_timing_pkg::*;
#(
    parameter int HOR_ACTIVE_PIXELS = NOM_HOR_ACTIVE,
    parameter int VER_ACTIVE_PIXELS = NOM_VER_ACTIVE,
    parameter int HOR_TOTAL_PIXELS  = NOM_HOR_TOTAL,
    parameter int VER_TOTAL_PIXELS  = NOM_VER_TOTAL,
    parameter int LOCK_FRAMES       = NOM_LOCK_FRAMES,
    localparam int XW  = $clog2(HOR_ACTIVE_PIXELS),
    localparam int YW  = $clog2(VER_ACTIVE_PIXELS),
    localparam int HMW = $clog2(HOR_TOTAL_PIXELS) + 1,
    localparam int VMW = $clog2(VER_TOTAL_PIXELS) + 1
) (
    input  logic                    clk_rgb,
    input  logic                    rst,
    video_timing_detector_if.slave  vin,
    output logic [XW-1:0]           x,
    output logic [YW-1:0]           y,
    output logic                    de_out,
    output logic                    line_start,
    output logic                    frame_start,
    output logic [HMW-1:0]          h_active_meas,
    output logic [VMW-1:0]          v_active_meas,
    output logic                    locked,
    output logic                    timing_err,
    output vtd_state_e              dbg_state
);
    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam logic [XW-1:0]  X_MAX    = XW'(HOR_ACTIVE_PIXELS - 1);
    localparam logic [YW-1:0]  Y_MAX    = YW'(VER_ACTIVE_PIXELS - 1);
    localparam logic [HMW-1:0] H_NOM    = HMW'(HOR_ACTIVE_PIXELS);
    localparam logic [HMW-1:0] H_SAT    = '1;
    localparam logic [VMW-1:0] V_NOM    = VMW'(VER_ACTIVE_PIXELS);
    localparam logic [VMW-1:0] V_TOT    = VMW'(VER_TOTAL_PIXELS);
    localparam logic [VMW-1:0] V_SAT    = VMW'(VER_TOTAL_PIXELS + 1);
    localparam logic [GW-1:0]  LOCK_CNT = GW'(LOCK_FRAMES);

    logic de_rise, de_fall, vs_rise, vs_fall;
    logic unused_sig;

    sync_edge_detector u_de_edge (
        .clk_rgb (clk_rgb),
        .rst     (rst),
        .ce      (vin.ce),
        .sig_in  (vin.de_in),
        .rise    (de_rise),
        .fall    (de_fall)
    );

    sync_edge_detector u_vs_edge (
        .clk_rgb (clk_rgb),
        .rst     (rst),
        .ce      (vin.ce),
        .sig_in  (vin.vs_in),
        .rise    (vs_rise),
        .fall    (vs_fall)
    );

    // hsync carries no information beyond what de edges already give.
    assign unused_sig = vin.hs_in ^ vs_fall;

    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic           de_q, de_d;
    logic           line_start_q, line_start_d;
    logic           frame_start_q, frame_start_d;
    logic [HMW-1:0] h_meas_q, h_meas_d;
    logic [VMW-1:0] v_meas_q, v_meas_d;
    logic [HMW-1:0] h_cnt_q, h_cnt_d;
    logic [VMW-1:0] v_cnt_q, v_cnt_d;
    logic           armed_q, armed_d;
    logic           seen_vs_q, seen_vs_d;
    logic           timing_err_q, timing_err_d;
    logic           line_err, frame_err;

    vtd_state_e     state_q, state_d;
    logic [GW-1:0]  good_q, good_d;

    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        de_d          = de_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        h_meas_d      = h_meas_q;
        v_meas_d      = v_meas_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        armed_d       = armed_q;
        seen_vs_d     = seen_vs_q;
        line_err      = 1'b0;
        frame_err     = 1'b0;
        if (vin.ce) begin
            de_d = vin.de_in;
            if (de_rise) begin
                x_d           = '0;
                h_cnt_d       = HMW'(1);
                line_start_d  = seen_vs_q;
                frame_start_d = armed_q;
                armed_d       = 1'b0;
            end else if (vin.de_in) begin
                if (x_q != X_MAX) x_d = x_q + 1'b1;
                if (h_cnt_q != H_SAT) h_cnt_d = h_cnt_q + 1'b1;
            end
            // A line ending on the vs edge is counted before the frame is judged.
            if (de_fall) begin
                h_meas_d = h_cnt_q;
                line_err = (h_cnt_q != H_NOM);
                if (y_q != Y_MAX) y_d = y_q + 1'b1;
                if (v_cnt_q != V_SAT) begin
                    v_cnt_d   = v_cnt_q + 1'b1;
                    frame_err = (v_cnt_q == V_TOT);
                end
            end
            if (vs_rise) begin
                v_meas_d  = v_cnt_d;
                if (v_cnt_d != V_NOM) frame_err = 1'b1;
                v_cnt_d   = '0;
                y_d       = '0;
                armed_d   = 1'b1;
                seen_vs_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_rgb) begin
        if (rst) begin
            x_q           <= '0;
            y_q           <= '0;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            h_meas_q      <= '0;
            v_meas_q      <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            armed_q       <= 1'b0;
            seen_vs_q     <= 1'b0;
            timing_err_q  <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            h_meas_q      <= h_meas_d;
            v_meas_q      <= v_meas_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            armed_q       <= armed_d;
            seen_vs_q     <= seen_vs_d;
            timing_err_q  <= timing_err_d;
        end
    end

    always_ff @(posedge clk_rgb) begin
        if (rst) begin
            state_q <= SEARCH;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        if (vin.ce) begin
            case (state_q)
                SEARCH: begin
                    if (vs_rise) begin
                        state_d = MEASURE;
                        good_d  = '0;
                    end
                end
                MEASURE: begin
                    if (line_err || frame_err) begin
                        state_d = SEARCH;
                        good_d  = '0;
                    end else if (vs_rise) begin
                        good_d = good_q + 1'b1;
                        if (good_d >= LOCK_CNT) state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (line_err || frame_err) begin
                        state_d = SEARCH;
                        good_d  = '0;
                    end
                end
                default: begin
                    state_d = SEARCH;
                    good_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        locked       = (state_q == LOCKED);
        timing_err_d = vin.ce && (state_q != SEARCH) && (line_err || frame_err);
    end

    assign x             = x_q;
    assign y             = y_q;
    assign de_out        = de_q;
    assign line_start    = line_start_q;
    assign frame_start   = frame_start_q;
    assign h_active_meas = h_meas_q;
    assign v_active_meas = v_meas_q;
    assign timing_err    = timing_err_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_video_timing_detector.sv
// Directed raster scenarios for video_timing_detector with a per-cycle expected-output scoreboard.
module tb_video_timing_detector;
    import video_timing_pkg::*;

    localparam int HA = 8;
    localparam int VA = 4;
    localparam int HT = 12;
    localparam int VT = 6;
    localparam int LF = 2;
    localparam int EW = 19;

    logic clk_rgb = 1'b0;
    logic rst = 1'b1;
    video_timing_detector_if vif ();

    logic [2:0] x;
    logic [1:0] y;
    logic       de_out, line_start, frame_start, locked, timing_err;
    logic [4:0] h_meas;
    logic [3:0] v_meas;
    vtd_state_e dbg_state;

    always #5 clk_rgb = ~clk_rgb;

    video_timing_detector #(
        .HOR_ACTIVE_PIXELS (HA),
        .VER_ACTIVE_PIXELS (VA),
        .HOR_TOTAL_PIXELS  (HT),
        .VER_TOTAL_PIXELS  (VT),
        .LOCK_FRAMES       (LF)
    ) dut (
        .clk_rgb       (clk_rgb),
        .rst           (rst),
        .vin           (vif),
        .x             (x),
        .y             (y),
        .de_out        (de_out),
        .line_start    (line_start),
        .frame_start   (frame_start),
        .h_active_meas (h_meas),
        .v_active_meas (v_meas),
        .locked        (locked),
        .timing_err    (timing_err),
        .dbg_state     (dbg_state)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [EW-1:0] exp_q[$];

    // reference raster model state
    int m_pde = 0, m_pvs = 0, m_hc = 0, m_vc = 0, m_armed = 0, m_seen = 0, m_st = 0, m_good = 0;
    int e_x = 0, e_y = 0, e_de = 0, e_ls = 0, e_fs = 0, e_hm = 0, e_vm = 0, e_lock = 0, e_te = 0;

    // strobe monitor
    int terr_cnt = 0, fs_cnt = 0, ls_cnt = 0, long_cnt = 0, max_x = 0;
    logic p_te = 1'b0, p_fs = 1'b0, p_ls = 1'b0;

    always @(negedge clk_rgb) begin
        if (timing_err) terr_cnt++;
        if (frame_start) fs_cnt++;
        if (line_start) ls_cnt++;
        if ((timing_err && p_te) || (frame_start && p_fs) || (line_start && p_ls)) long_cnt++;
        if (de_out && (int'(x) > max_x)) max_x = int'(x);
        p_te = timing_err;
        p_fs = frame_start;
        p_ls = line_start;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit c, input bit d, input bit v);
        bit rd, fd, rv, lerr, ferr;
        if (r) begin
            m_pde = 0; m_pvs = 0; m_hc = 0; m_vc = 0; m_armed = 0; m_seen = 0; m_st = 0; m_good = 0;
            e_x = 0; e_y = 0; e_de = 0; e_ls = 0; e_fs = 0; e_hm = 0; e_vm = 0; e_lock = 0; e_te = 0;
        end else if (!c) begin
            e_ls = 0; e_fs = 0; e_te = 0;
        end else begin
            rd = d && (m_pde == 0);
            fd = !d && (m_pde == 1);
            rv = v && (m_pvs == 0);
            m_pde = int'(d);
            m_pvs = int'(v);
            lerr = 0; ferr = 0;
            e_ls = 0; e_fs = 0; e_te = 0;
            e_de = int'(d);
            if (rd) begin
                e_x = 0; m_hc = 1; e_ls = m_seen; e_fs = m_armed; m_armed = 0;
            end else if (d) begin
                if (e_x < HA - 1) e_x++;
                m_hc++;
            end
            if (fd) begin
                e_hm = m_hc;
                lerr = (m_hc != HA);
                if (e_y < VA - 1) e_y++;
                if (m_vc < VT + 1) begin
                    m_vc++;
                    if (m_vc == VT + 1) ferr = 1;
                end
            end
            if (rv) begin
                e_vm = m_vc;
                if (m_vc != VA) ferr = 1;
                m_vc = 0; e_y = 0; m_armed = 1; m_seen = 1;
            end
            if (m_st == 0) begin
                if (rv) begin m_st = 1; m_good = 0; end
            end else if (lerr || ferr) begin
                e_te = 1; m_st = 0; m_good = 0;
            end else if (rv && m_st == 1) begin
                m_good++;
                if (m_good >= LF) m_st = 2;
            end
            e_lock = (m_st == 2) ? 1 : 0;
        end
    endtask

    task automatic step(input bit r, input bit c, input bit d, input bit h, input bit v);
        logic [EW-1:0] e, o;
        @(negedge clk_rgb);
        rst = r;
        vif.ce = c;
        vif.de_in = d;
        vif.hs_in = h;
        vif.vs_in = v;
        model(r, c, d, v);
        exp_q.push_back({3'(e_x), 2'(e_y), 1'(e_de), 1'(e_ls), 1'(e_fs), 5'(e_hm), 4'(e_vm),
                         1'(e_lock), 1'(e_te)});
        @(posedge clk_rgb);
        #1;
        cyc++;
        o = {x, y, de_out, line_start, frame_start, h_meas, v_meas, locked, timing_err};
        e = exp_q.pop_front();
        check($sformatf("sb@%0d", cyc), 32'(o), 32'(e));
    endtask

    task automatic drive_line(input int n_de, input bit v, input int ce_div);
        for (int p = 0; p < HT; p++)
            for (int k = 0; k < ce_div; k++)
                step(1'b0, k == 0, p < n_de, p == HT - 2, v);
    endtask

    task automatic drive_frame(input int first_line, input int n_act, input int long_line,
                               input bit vs_on, input int ce_div);
        for (int l = first_line; l < VT; l++)
            drive_line((l < n_act) ? ((l == long_line) ? HA + 1 : HA) : 0,
                       vs_on && (l == VT - 1), ce_div);
    endtask

    int te0, fs0, ls0;

    initial begin
        vif.ce = 1'b0;
        vif.de_in = 1'b0;
        vif.hs_in = 1'b0;
        vif.vs_in = 1'b0;

        // nominal raster from reset
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_outs", 32'({x, y, de_out, line_start, frame_start, h_meas, v_meas, locked, timing_err}), 0);
        check("reset_state", 32'(dbg_state), 32'(SEARCH));
        repeat (3) drive_frame(0, VA, -1, 1'b1, 1);
        check("t1_locked", 32'(locked), 1);
        check("t1_hmeas", 32'(h_meas), 8);
        check("t1_vmeas", 32'(v_meas), 4);
        check("t1_terr", terr_cnt, 0);
        check("t1_maxx", max_x, 7);
        check("t1_fs", fs_cnt, 2);
        check("t1_ls", ls_cnt, 8);

        // one line with 9 de pixels
        te0 = terr_cnt;
        drive_line(HA, 1'b0, 1);
        drive_line(HA + 1, 1'b0, 1);
        check("t2_hmeas", 32'(h_meas), 9);
        check("t2_locked", 32'(locked), 0);
        check("t2_state", 32'(dbg_state), 32'(SEARCH));
        check("t2_terr", terr_cnt - te0, 1);
        check("t2_maxx", max_x, 7);
        drive_frame(2, VA, -1, 1'b1, 1);

        // frame with 3 active lines
        te0 = terr_cnt;
        drive_frame(0, 3, -1, 1'b1, 1);
        check("t3_vmeas", 32'(v_meas), 3);
        check("t3_terr", terr_cnt - te0, 1);
        check("t3_locked", 32'(locked), 0);
        repeat (3) drive_frame(0, VA, -1, 1'b1, 1);
        check("t3_relock", 32'(locked), 1);

        // pixel enable 1-in-3
        te0 = terr_cnt;
        fs0 = fs_cnt;
        repeat (3) drive_frame(0, VA, -1, 1'b1, 3);
        check("t4_locked", 32'(locked), 1);
        check("t4_terr", terr_cnt - te0, 0);
        check("t4_fs", fs_cnt - fs0, 3);
        check("t4_hmeas", 32'(h_meas), 8);
        check("t4_vmeas", 32'(v_meas), 4);
        check("t4_strobe_width", long_cnt, 0);

        // reset in the middle of a line while locked
        drive_line(HA, 1'b0, 1);
        drive_line(HA, 1'b0, 1);
        for (int p = 0; p < 4; p++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("t5_rst_outs", 32'({x, y, de_out, line_start, frame_start, h_meas, v_meas, locked, timing_err}), 0);
        check("t5_rst_state", 32'(dbg_state), 32'(SEARCH));
        fs0 = fs_cnt;
        ls0 = ls_cnt;
        for (int p = 5; p < HT; p++) step(1'b0, 1'b1, p < HA, p == HT - 2, 1'b0);
        drive_frame(3, VA, -1, 1'b1, 1);
        check("t5_no_fs", fs_cnt - fs0, 0);
        check("t5_no_ls", ls_cnt - ls0, 0);
        check("t5_vmeas", 32'(v_meas), 2);
        fs0 = fs_cnt;
        drive_frame(0, VA, -1, 1'b1, 1);
        check("t5_fs_after_vs", fs_cnt - fs0, 1);

        // missing vsync for one frame
        drive_frame(0, VA, -1, 1'b1, 1);
        check("t6_prelock", 32'(locked), 1);
        te0 = terr_cnt;
        drive_frame(0, VA, -1, 1'b0, 1);
        check("t6_novs_terr", terr_cnt - te0, 0);
        drive_frame(0, VA, -1, 1'b1, 1);
        check("t6_terr", terr_cnt - te0, 1);
        check("t6_locked", 32'(locked), 0);
        check("t6_vmeas", 32'(v_meas), 7);
        repeat (2) drive_frame(0, VA, -1, 1'b1, 1);
        check("t6_relock", 32'(locked), 1);
        check("t6_strobe_width", long_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
